// File: rtl/mmio_io_port_if.sv
// CPU data-bus and stream signals of the mmio_io_port responder, grouped as one bundle.
interface mmio_io_port_if;
    logic [15:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic        Hit;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport slave (
        input  Addr, WriteData, MemWrite, MemRead, out_ready, in_data, in_valid,
        output Hit, ReadData, out_data, out_valid, in_ready
    );

    modport master (
        output Addr, WriteData, MemWrite, MemRead, out_ready, in_data, in_valid,
        input  Hit, ReadData, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/mmio_io_port.sv
// MMIO responder: OUT0 store queue to a valid/ready consumer, IN0 holding register, STATUS.
// Define MMIO_OUT_FIFO_EN for a 4-deep output queue; otherwise a single output register.
module mmio_io_port #(
    parameter logic [15:0] OUT0_ADDR   = 16'd256,
    parameter logic [15:0] STATUS_ADDR = 16'd264,
    parameter logic [15:0] IN0_ADDR    = 16'd272
) (
    input  logic           clk,
    input  logic           rst,
    mmio_io_port_if.slave  bus
);

    logic hit_out, hit_stat, hit_in;
    logic push, pop, push_acc;
    logic out_valid, out_full;
    logic [31:0] head;
    logic ovf_q, ovf_d;
    logic in_full_q, in_full_d;
    logic [31:0] in_buf_q, in_buf_d;
    logic addr_unused;

    // Byte-lane bits never take part in decode.
    assign addr_unused = ^bus.Addr[1:0];

    assign hit_out  = (bus.Addr[15:2] == OUT0_ADDR[15:2]);
    assign hit_stat = (bus.Addr[15:2] == STATUS_ADDR[15:2]);
    assign hit_in   = (bus.Addr[15:2] == IN0_ADDR[15:2]);
    assign bus.Hit  = hit_out | hit_stat | hit_in;

    assign push     = bus.MemWrite & hit_out;
    assign pop      = out_valid & bus.out_ready;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign push_acc = push & (~out_full | pop);

`ifdef MMIO_OUT_FIFO_EN
    logic [31:0] mem_q [0:3];
    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;

    assign out_valid = (count_q != 3'd0);
    assign out_full  = (count_q == 3'd4);
    assign head      = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wptr_q] <= bus.WriteData;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_acc) begin
            wptr_d = wptr_q + 2'd1;
        end
        if (pop) begin
            rptr_d = rptr_q + 2'd1;
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
`else
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    assign out_valid = valid_q;
    assign out_full  = valid_q;
    assign head      = data_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (push_acc) begin
            data_d  = bus.WriteData;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head : 32'd0;
    assign bus.in_ready  = ~in_full_q;

    always_comb begin
        ovf_d     = ovf_q;
        in_full_d = in_full_q;
        in_buf_d  = in_buf_q;
        if (bus.MemWrite & hit_stat & bus.WriteData[3]) begin
            ovf_d = 1'b0;
        end
        if (push & out_full & ~pop) begin
            ovf_d = 1'b1;
        end
        // in_ready is low while full, so load and consume are mutually exclusive.
        if (bus.in_valid & ~in_full_q) begin
            in_full_d = 1'b1;
            in_buf_d  = bus.in_data;
        end else if (bus.MemRead & hit_in & in_full_q) begin
            in_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q     <= 1'b0;
            in_full_q <= 1'b0;
            in_buf_q  <= 32'd0;
        end else begin
            ovf_q     <= ovf_d;
            in_full_q <= in_full_d;
            in_buf_q  <= in_buf_d;
        end
    end

    always_comb begin
        bus.ReadData = 32'd0;
        if (hit_stat) begin
            bus.ReadData = {28'd0, ovf_q, ~out_valid, out_full, in_full_q};
        end else if (hit_in & in_full_q) begin
            bus.ReadData = in_buf_q;
        end
    end

endmodule

// File: doc/mmio_io_port.md
# mmio_io_port

Memory-mapped I/O responder sitting on the CPU data-memory bus beside `dmem`. It decodes `OUT0` (0x100), `STATUS` (0x108) and `IN0` (0x110). CPU stores to `OUT0` are queued and streamed to an external consumer over a valid/ready channel. An external producer's word is held for the CPU to read from `IN0`. It is the device side of the load/store I/O traffic issued by the MIPS pipeline.

## Interface
Parameters:
- `OUT0_ADDR`, 16'd256: output data register address.
- `STATUS_ADDR`, 16'd264: status/control register address.
- `IN0_ADDR`, 16'd272: input data register address.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `Addr`  in  16  byte address from the MEM stage; decode compares `Addr[15:2]` only.
- `WriteData`  in  32  store data.
- `MemWrite`  in  1  store strobe for this cycle.
- `MemRead`  in  1  load strobe for this cycle.
- `Hit`  out  1  combinational; `Addr` matches one of the three registers. Top-level uses it to mux `ReadData` over `dmem`.
- `ReadData`  out  32  combinational read data.
- `out_data`  out  32  head of the output queue.
- `out_valid`  out  1  output queue non-empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `in_data`  in  32  producer word.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  registered; equals NOT `in_full`.

## Operation
- Output queue: circular buffer of depth `OQ_DEPTH`, with 2-bit read/write pointers and a 3-bit `count`.
  - Push: `MemWrite` and decode==`OUT0`.
  - Pop: `out_valid` and `out_ready`.
  - All 32 bits of `WriteData` are pushed regardless of store width (SB/SH/SW).
- Push when `count==OQ_DEPTH` and no pop in the same cycle: the word is dropped and sticky `ovf` is set.
- Push and pop in the same cycle while full: both take effect, `count` is unchanged, `ovf` is not set.
- Pointers wrap modulo `OQ_DEPTH`.
- Input holding register: `in_buf`(32) plus `in_full`.
  - Load: `in_valid` and `in_ready` in a cycle sets `in_full` and captures `in_data`.
  - Consume: `MemRead` and decode==`IN0` and `in_full` clears `in_full`.
  - Read of `IN0` while empty returns 0 with no state change.
  - Since `in_ready` is registered, load and consume never coincide.
- `STATUS` read value: `{28'b0, ovf, out_empty, out_full, in_full}`, with bit0 = `in_full`.
- `STATUS` write: `WriteData[3]`=1 clears `ovf`; all other bits are ignored.
- `OUT0` reads return 0. `IN0` writes are ignored.
- Strobes with `Hit`=0 have no effect; `ReadData`=0 when `Hit`=0.

## Timing
- Reset (`rst`=0, asynchronous) clears pointers, `count`, `ovf`, `in_full` and `in_buf`.
  - Outputs while in reset: `out_valid`=0, `out_data`=0, `in_ready`=1, `ReadData`/`Hit` decode-only (read data 0).
  - Reset asserted mid-transfer discards queued and held data.
- A store at edge N gives `out_valid`=1 and `out_data`=stored word after edge N (visible in cycle N+1).
- A producer handshake at edge N makes `IN0` readable and `STATUS[0]`=1 from cycle N+1.
  - `in_ready`=0 until the edge following the CPU read.
- `ReadData` is combinational from `Addr` and the current state, so a load completes in its MEM cycle. A load and the consume of `in_buf` happen on the same edge.
- Consecutive SW to `OUT0` every cycle are accepted back-to-back until full.

## Configuration
- `MMIO_OUT_FIFO_EN` defined: `OQ_DEPTH`=4 (circular buffer as above).
- `MMIO_OUT_FIFO_EN` undefined: `OQ_DEPTH`=1, a single register with pointers removed.
  - `out_full` equals `out_valid`.
  - Simultaneous push and pop while full is still accepted.

## Test plan
- Reset: drive `rst`=0 for 1 ns with `clk` idle → `out_valid`=0, `in_ready`=1, STATUS read = 0x4.
- Four SW to 0x100 with data 0x11, 0x22, 0x33, 0x44 and `out_ready`=0 → STATUS=0x2. A fifth SW of 0x55 → STATUS=0xA. Then hold `out_ready`=1 → 0x11, 0x22, 0x33, 0x44 in order, then `out_valid`=0.
- While full, SW of 0x66 in the same cycle as a pop → no overflow flag; the stream tail is 0x66. Writing STATUS with 0x8 after an overflow clears bit3.
- Producer offers 0xDEADBEEF → next cycle STATUS[0]=1 and `in_ready`=0. LW from 0x110 returns 0xDEADBEEF. A second LW returns 0, and `in_ready`=1 again.
- SB to 0x100 with `WriteData`=0xFFFFFFFE → `out_data`=0xFFFFFFFE. LW from 0x100 returns 0. A store to 0x104 gives `Hit`=0 and no push.
- Reset asserted with 2 words queued and `in_full`=1 → immediately `out_valid`=0, `in_ready`=1, STATUS=0x4.
- Repeat the depth test without the macro → the second SW sets `ovf`.
